led_sequence_player: RTL and testbench

- Plays a stored colour sequence on the four game LEDs (red, blue, green, yellow) so the player can watch the pattern before repeating it.
- Steps through a synchronous sequence memory one entry at a time, showing each colour for a fixed on-time followed by an all-off gap, then pulses done.
- Sits between the game FSM (start/abort/length) and the LED pins.
- Sole owner of the LED outputs while busy.

---
 rtl/led_sequence_player.sv | 171 +++++++++++++++++
 tb/tb_led_sequence_player.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequence_player.sv
// led_sequence_player: plays a stored colour sequence on the four game LEDs.
// It steps through a synchronous sequence memory. Each step shows one colour
// for ON_CYCLES and then keeps all LEDs dark for OFF_CYCLES. When the whole
// sequence has played, done pulses for one cycle.
// LED order inside leds_q: bit0 red, bit1 blue, bit2 green, bit3 yellow.
module led_sequence_player #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int ON_CYCLES  = CLOCK_FREQ / 2,
  parameter int OFF_CYCLES = CLOCK_FREQ / 4,
  parameter int MAX_LEN    = 32,
  parameter int ADDR_W     = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   seq_len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_data,
  output logic              red_led,
  output logic              blue_led,
  output logic              green_led,
  output logic              yellow_led,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [31:0]     ON_LOAD   = 32'(ON_CYCLES - 1);
  localparam logic [31:0]     OFF_LOAD  = 32'(OFF_CYCLES - 1);
  localparam logic [ADDR_W:0] MAX_LEN_W = (ADDR_W + 1)'(MAX_LEN);
  localparam logic [ADDR_W:0] ONE_LEN   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_IDX = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [3:0]        leds_q, leds_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W:0]   len_clamped;
  logic              last_step;

  // Next-state and registered-output logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    leds_d  = leds_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    len_clamped = (seq_len > MAX_LEN_W) ? MAX_LEN_W : seq_len;
    // idx is zero-extended so the compare never wraps at the top address.
    last_step   = (({1'b0, idx_q} + ONE_LEN) == len_q);

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          len_d  = len_clamped;
          idx_d  = '0;
          addr_d = '0;
          if (len_clamped == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_ADDR;
            busy_d  = 1'b1;
          end
        end
      end
      S_ADDR: begin
        // The memory samples mem_addr on this edge.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // mem_data is valid now; light exactly one LED.
        leds_d  = 4'b0001 << mem_data;
        cnt_d   = ON_LOAD;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (cnt_q == '0) begin
          leds_d  = 4'b0000;
          cnt_d   = OFF_LOAD;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (last_step) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d   = idx_q + ONE_IDX;
            addr_d  = idx_q + ONE_IDX;
            state_d = S_ADDR;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_DONE: begin
        // A start seen here is ignored; IDLE picks it up on the next edge.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      leds_d  = 4'b0000;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      addr_d  = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      leds_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_addr   = addr_q;
  assign red_led    = leds_q[0];
  assign blue_led   = leds_q[1];
  assign green_led  = leds_q[2];
  assign yellow_led = leds_q[3];
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_led_sequence_player.sv
// Testbench for led_sequence_player (ON=4, OFF=2, MAX_LEN=8, ADDR_W=3).
// Edge numbering: E0 is the edge that samples start. All values are sampled 1 time
// unit after each rising edge.
module tb_led_sequence_player;

  localparam logic [3:0] RED = 4'b0001;
  localparam logic [3:0] BLU = 4'b0010;
  localparam logic [3:0] GRN = 4'b0100;
  localparam logic [3:0] YEL = 4'b1000;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] seq_len;
  logic [2:0] mem_addr;
  logic [1:0] mem_data;
  logic       red_led, blue_led, green_led, yellow_led, busy, done;

  logic [1:0] mem [8];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] mask;    // bit r set: row applies to run r
    int         edge_n;
    logic [3:0] leds;
    logic       busy;
    logic       done;
    int         addr;    // -1: not checked
  } vec_t;

  vec_t vecs[$];

  logic [3:0] obs_leds [80];
  logic       obs_busy [80];
  logic       obs_done [80];
  logic [2:0] obs_addr [80];

  int run_len   [4] = '{3, 0, 12, 3};
  int run_hold  [4] = '{1, 1, 1, 26};
  int run_edges [4] = '{27, 4, 66, 27};

  led_sequence_player #(
    .CLOCK_FREQ(100),
    .ON_CYCLES (4),
    .OFF_CYCLES(2),
    .MAX_LEN   (8),
    .ADDR_W    (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .seq_len   (seq_len),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .red_led   (red_led),
    .blue_led  (blue_led),
    .green_led (green_led),
    .yellow_led(yellow_led),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  // One-cycle synchronous sequence memory.
  always @(posedge clock) mem_data <= mem[mem_addr];

  function automatic logic [3:0] leds_now();
    return {yellow_led, green_led, blue_led, red_led};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  // Advance one edge and check the one-hot LED invariant.
  task automatic tick();
    @(posedge clock);
    #1;
    n_checks++;
    if ($countones(leds_now()) > 1) begin
      n_fail++;
      $display("FAIL onehot at %0t: leds=%b, expected at most one set", $time, leds_now());
    end
  endtask

  task automatic add(input logic [3:0] m, input int e, input logic [3:0] l,
                     input logic b, input logic d, input int a);
    vec_t v;
    v.mask = m; v.edge_n = e; v.leds = l; v.busy = b; v.done = d; v.addr = a;
    vecs.push_back(v);
  endtask

  task automatic run_play(input logic [3:0] len, input int hold, input int n_edges);
    seq_len = len;
    start   = 1'b1;
    for (int k = 0; k < n_edges; k++) begin
      tick();
      if (k + 1 >= hold) start = 1'b0;
      obs_leds[k] = leds_now();
      obs_busy[k] = busy;
      obs_done[k] = done;
      obs_addr[k] = mem_addr;
    end
    start = 1'b0;
  endtask

  task automatic check_vec(input int r, input vec_t v);
    int  e;
    bit  ok;
    e  = v.edge_n;
    ok = (obs_leds[e] === v.leds) && (obs_busy[e] === v.busy) && (obs_done[e] === v.done)
         && ((v.addr < 0) || (int'(obs_addr[e]) == v.addr));
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL run%0d E%0d: got leds=%b busy=%b done=%b addr=%0d, expected leds=%b busy=%b done=%b addr=%0d",
               r, e, obs_leds[e], obs_busy[e], obs_done[e], obs_addr[e], v.leds, v.busy, v.done, v.addr);
    end else begin
      $display("ok   run%0d E%0d leds=%b busy=%b done=%b addr=%0d",
               r, e, obs_leds[e], obs_busy[e], obs_done[e], obs_addr[e]);
    end
  endtask

  initial begin
    int done_seen;
    int busy_seen;

    mem[0] = 2'd0; mem[1] = 2'd2; mem[2] = 2'd3; mem[3] = 2'd1;
    mem[4] = 2'd0; mem[5] = 2'd0; mem[6] = 2'd0; mem[7] = 2'd1;

    // Runs 0 and 3 (mask 1001): seq_len=3, red/green/yellow.
    add(4'b1001,  0, 4'b0, 1, 0, 0);
    add(4'b1001,  1, 4'b0, 1, 0, 0);
    add(4'b1001,  2, RED,  1, 0, 0);
    add(4'b1001,  5, RED,  1, 0, 0);
    add(4'b1001,  6, 4'b0, 1, 0, 0);
    add(4'b1001,  7, 4'b0, 1, 0, 0);
    add(4'b1001,  8, 4'b0, 1, 0, 1);
    add(4'b1001, 10, GRN,  1, 0, 1);
    add(4'b1001, 13, GRN,  1, 0, 1);
    add(4'b1001, 14, 4'b0, 1, 0, 1);
    add(4'b1001, 16, 4'b0, 1, 0, 2);
    add(4'b1001, 18, YEL,  1, 0, 2);
    add(4'b1001, 21, YEL,  1, 0, 2);
    add(4'b1001, 22, 4'b0, 1, 0, 2);
    add(4'b1001, 23, 4'b0, 1, 0, 2);
    add(4'b1001, 24, 4'b0, 0, 1, -1);
    add(4'b1001, 25, 4'b0, 0, 0, -1);
    add(4'b1001, 26, 4'b0, 0, 0, -1);
    // Run 1: seq_len=0 -> immediate done, never busy.
    add(4'b0010,  0, 4'b0, 0, 1, 0);
    add(4'b0010,  1, 4'b0, 0, 0, 0);
    add(4'b0010,  3, 4'b0, 0, 0, 0);
    // Run 2: seq_len=12 clamps to 8 steps.
    add(4'b0100,  0, 4'b0, 1, 0, 0);
    add(4'b0100,  2, RED,  1, 0, 0);
    add(4'b0100, 10, GRN,  1, 0, 1);
    add(4'b0100, 18, YEL,  1, 0, 2);
    add(4'b0100, 26, BLU,  1, 0, 3);
    add(4'b0100, 34, RED,  1, 0, 4);
    add(4'b0100, 50, RED,  1, 0, 6);
    add(4'b0100, 56, 4'b0, 1, 0, 7);
    add(4'b0100, 58, BLU,  1, 0, 7);
    add(4'b0100, 61, BLU,  1, 0, 7);
    add(4'b0100, 62, 4'b0, 1, 0, 7);
    add(4'b0100, 63, 4'b0, 1, 0, 7);
    add(4'b0100, 64, 4'b0, 0, 1, -1);
    add(4'b0100, 65, 4'b0, 0, 0, -1);

    reset = 1'b1; start = 1'b0; abort = 1'b0; seq_len = '0;
    repeat (3) tick();
    check("reset_leds", 32'(leds_now()), 32'h0);
    check("reset_busy_done_addr", {27'b0, busy, done, mem_addr}, 32'h0);
    reset = 1'b0;
    tick();

    // Table-driven playback runs.
    for (int r = 0; r < 4; r++) begin
      run_play(4'(run_len[r]), run_hold[r], run_edges[r]);
      foreach (vecs[v]) begin
        if (vecs[v].mask[r]) check_vec(r, vecs[v]);
      end
      repeat (2) tick();
    end

    // Abort in the gap of the second step.
    seq_len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    check("pre_abort_gap", {26'b0, leds_now(), busy, mem_addr == 3'd1}, {26'b0, 4'b0, 1'b1, 1'b1});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_outputs", {26'b0, leds_now(), busy, done}, 32'h0);
    check("abort_addr", 32'(mem_addr), 32'h0);
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done || busy) done_seen++;
    end
    check("abort_quiet", 32'(done_seen), 32'h0);

    // Replay after abort starts again from address 0.
    seq_len = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("replay_E0", {28'b0, busy, mem_addr}, {28'b0, 1'b1, 3'd0});
    repeat (2) tick();
    check("replay_E2_red", 32'(leds_now()), 32'(RED));
    repeat (14) tick();
    check("replay_E16_done", {30'b0, busy, done}, 32'h1);
    repeat (2) tick();

    // start and abort together in IDLE: abort wins.
    seq_len = 4'd3; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("idle_abort_start", {29'b0, busy, done, red_led}, 32'h0);
    repeat (2) tick();

    // Asynchronous reset while red is lit.
    seq_len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("pre_reset_red", 32'(leds_now()), 32'(RED));
    #2 reset = 1'b1;
    #1;
    check("async_reset_clear", {26'b0, leds_now(), busy, done}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    check("post_reset_no_done", 32'(done_seen), 32'h0);
    check("post_reset_idle", 32'(busy_seen), 32'h0);
    seq_len = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("post_reset_play", {27'b0, leds_now(), busy}, {27'b0, RED, 1'b1});
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
